branch_resolve_unit: RTL and testbench

- Sits directly downstream of the EX-stage branch comparator.
- Consumes the comparator's taken flag together with the branch/jump target and decides whether the front end must redirect.
- Drives a registered PC redirect and a multi-cycle flush of the younger stages.
- Maintains a 2-bit branch history table, read by the ID stage for static-target prediction, plus branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit_pkg.sv | 27 ++
 rtl/branch_resolve_unit_bht.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 110 +++++++++++
 tb/tb_branch_resolve_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: BHT counter encodings,
// flush state type and the saturating counter update.
package branch_resolve_unit_pkg;

    localparam logic [1:0] BHT_SNT   = 2'b00;
    localparam logic [1:0] BHT_WNT   = 2'b01;
    localparam logic [1:0] BHT_WT    = 2'b10;
    localparam logic [1:0] BHT_ST    = 2'b11;
    localparam logic [1:0] BHT_RESET = BHT_WNT;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSHING
    } flush_state_e;

    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != BHT_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != BHT_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating branch history table: one combinational read port and one
// update port; a same-cycle read sees the pre-update value.
module branch_history_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int BHT_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output logic                 rd_taken,
    input  logic                 upd_en,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken
);

    localparam int ENTRIES = 1 << BHT_IDX_W;

    logic [1:0] ctr_all [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] ctr_q;
            logic [1:0] ctr_d;

            always_comb begin
                ctr_d = ctr_q;
                if (upd_en && (upd_idx == BHT_IDX_W'(gi))) begin
                    ctr_d = bht_next(ctr_q, upd_taken);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) ctr_q <= BHT_RESET;
                else     ctr_q <= ctr_d;
            end

            assign ctr_all[gi] = ctr_q;
        end
    endgenerate

    assign rd_taken = ctr_all[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps: registered PC redirect, multi-cycle flush
// of the younger stages, BHT training and branch/mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic        ex_flag,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        stall,
    input  logic [31:0] id_pc,
    output logic        id_pred_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    flush_state_e state_q, state_d;
    logic [2:0]   flush_cnt_q, flush_cnt_d;
    logic         flush_q, flush_d;
    logic         redirect_q, redirect_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  branch_cnt_q, branch_cnt_d;
    logic [31:0]  mispredict_cnt_q, mispredict_cnt_d;

    logic resolve, do_jump, do_branch;

    always_comb begin
        resolve   = ex_valid & ~stall & (state_q == ST_IDLE);
        do_jump   = resolve & ex_jump;
        do_branch = resolve & ex_branch & ~ex_jump;

        redirect_d       = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_cnt_d      = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        if (do_jump) begin
            redirect_d    = 1'b1;
            redirect_pc_d = ex_target;
            flush_cnt_d   = 3'(FLUSH_CYCLES);
        end else if (do_branch) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (ex_flag != ex_pred_taken) begin
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
                redirect_d       = 1'b1;
                redirect_pc_d    = ex_flag ? ex_target : ex_pc + 32'd4;
                flush_cnt_d      = 3'(FLUSH_CYCLES);
            end
        end

        // flush tracks the next count so it drops on the same edge the count hits 0
        flush_d = (flush_cnt_d != 3'd0);
        state_d = flush_d ? ST_FLUSHING : ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= 3'd0;
            flush_q          <= 1'b0;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= 32'd0;
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            flush_q          <= flush_d;
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    branch_history_table #(
        .BHT_IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (id_pc[BHT_IDX_W+1:2]),
        .rd_taken  (id_pred_taken),
        .upd_en    (do_branch),
        .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
        .upd_taken (ex_flag)
    );

    // Only the index field of id_pc participates in the lookup.
    logic unused_id_pc_bits;
    assign unused_id_pc_bits = ^{id_pc[31:BHT_IDX_W+2], id_pc[1:0]};

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_branch, ex_jump, ex_flag, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        stall;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_cnt, mispredict_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .BHT_IDX_W    (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_flag        (ex_flag),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .stall          (stall),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive(input logic b, input logic j, input logic f, input logic p,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic st);
        ex_valid      = 1'b1;
        ex_branch     = b;
        ex_jump       = j;
        ex_flag       = f;
        ex_pred_taken = p;
        ex_pc         = pc;
        ex_target     = tgt;
        stall         = st;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_flag = 1'b0;
        ex_pred_taken = 1'b0; ex_pc = 32'd0; ex_target = 32'd0; stall = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_pre;
        rst = 1'b1;
        idle();
        id_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_misp_cnt", mispredict_cnt, 32'd0);
        chk("rst_pred", 32'(id_pred_taken), 32'd0);
        rst = 1'b0;
        step();

        // Mispredicted taken BEQ: redirect to target, 2-cycle flush.
        drive(1, 0, 1, 0, 32'h100, 32'h80, 0);
        step(); idle();
        chk("beq_redirect", 32'(redirect), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h80);
        chk("beq_flush_c1", 32'(flush), 32'd1);
        chk("beq_branch_cnt", branch_cnt, 32'd1);
        chk("beq_misp_cnt", mispredict_cnt, 32'd1);
        step();
        chk("beq_redirect_off", 32'(redirect), 32'd0);
        chk("beq_flush_c2", 32'(flush), 32'd1);
        step();
        chk("beq_flush_end", 32'(flush), 32'd0);
        chk("beq_pc_hold", redirect_pc, 32'h80);
        id_pc = 32'h100; #1;
        chk("beq_bht_wt", 32'(id_pred_taken), 32'd1);

        // Correctly predicted not-taken BNEs walk idx0 down to SNT.
        drive(1, 0, 0, 0, 32'h200, 32'h999, 0);
        step(); idle();
        chk("bne1_redirect", 32'(redirect), 32'd0);
        chk("bne1_flush", 32'(flush), 32'd0);
        chk("bne1_branch_cnt", branch_cnt, 32'd2);
        chk("bne1_misp_cnt", mispredict_cnt, 32'd1);
        id_pc = 32'h200; #1;
        chk("bne1_pred", 32'(id_pred_taken), 32'd0);
        drive(1, 0, 0, 0, 32'h200, 32'h999, 0);
        step(); idle();
        chk("bne2_branch_cnt", branch_cnt, 32'd3);
        // One taken update from SNT lands on WNT (still predicts not-taken).
        drive(1, 0, 1, 1, 32'h200, 32'h999, 0);
        step(); idle();
        chk("snt_probe_redirect", 32'(redirect), 32'd0);
        chk("snt_probe_pred", 32'(id_pred_taken), 32'd0);
        chk("snt_probe_branch_cnt", branch_cnt, 32'd4);

        // JAL redirect; a mispredicted branch during the flush is ignored.
        drive(0, 1, 0, 0, 32'h40, 32'h1000, 0);
        step();
        chk("jal_redirect", 32'(redirect), 32'd1);
        chk("jal_redirect_pc", redirect_pc, 32'h1000);
        chk("jal_flush", 32'(flush), 32'd1);
        chk("jal_branch_cnt", branch_cnt, 32'd4);
        drive(1, 0, 1, 0, 32'h300, 32'h500, 0);
        step();
        chk("wrongpath_redirect", 32'(redirect), 32'd0);
        chk("wrongpath_flush", 32'(flush), 32'd1);
        step(); idle();
        chk("wrongpath_redirect2", 32'(redirect), 32'd0);
        chk("wrongpath_flush_end", 32'(flush), 32'd0);
        chk("wrongpath_branch_cnt", branch_cnt, 32'd4);
        chk("wrongpath_misp_cnt", mispredict_cnt, 32'd1);
        chk("wrongpath_pc_hold", redirect_pc, 32'h1000);
        id_pc = 32'h300; #1;
        chk("wrongpath_bht", 32'(id_pred_taken), 32'd0);

        // Stalled mispredict: no resolve until stall drops.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, 32'h500, 32'h900, 1);
            step();
            chk($sformatf("stall%0d_redirect", i), 32'(redirect), 32'd0);
            chk($sformatf("stall%0d_branch_cnt", i), branch_cnt, 32'd4);
        end
        drive(1, 0, 0, 1, 32'h500, 32'h900, 0);
        step(); idle();
        chk("unstall_redirect", 32'(redirect), 32'd1);
        chk("unstall_redirect_pc", redirect_pc, 32'h504);
        chk("unstall_branch_cnt", branch_cnt, 32'd5);
        chk("unstall_misp_cnt", mispredict_cnt, 32'd2);
        step(); step();

        // Branch and jump together: jump wins, counters untouched.
        drive(1, 1, 0, 0, 32'h600, 32'h2000, 0);
        step(); idle();
        chk("bj_redirect", 32'(redirect), 32'd1);
        chk("bj_redirect_pc", redirect_pc, 32'h2000);
        chk("bj_branch_cnt", branch_cnt, 32'd5);
        step(); step();

        // Fall-through PC wraps at 2^32.
        drive(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h1234, 0);
        step(); idle();
        chk("wrap_redirect", 32'(redirect), 32'd1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        chk("wrap_misp_cnt", mispredict_cnt, 32'd3);
        step(); step();

        // Four taken branches at 0x10; same-cycle read sees pre-update value.
        id_pc = 32'h10; #1;
        chk("bht10_init", 32'(id_pred_taken), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_pre = (i == 0) ? 1'b0 : 1'b1;
            drive(1, 0, 1, 1, 32'h10, 32'h88, 0);
            #1;
            chk($sformatf("bht10_same_cycle%0d", i), 32'(id_pred_taken), 32'(exp_pre));
            step(); idle();
            chk($sformatf("bht10_after%0d", i), 32'(id_pred_taken), 32'd1);
        end
        chk("bht10_branch_cnt", branch_cnt, 32'd10);
        chk("bht10_no_redirect", 32'(redirect), 32'd0);

        // Async reset in the middle of a flush.
        drive(1, 0, 1, 0, 32'h700, 32'h40, 0);
        step(); idle();
        chk("pre_rst_flush", 32'(flush), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_redirect", 32'(redirect), 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_branch_cnt", branch_cnt, 32'd0);
        chk("arst_misp_cnt", mispredict_cnt, 32'd0);
        chk("arst_bht_pred", 32'(id_pred_taken), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // From WNT a not-taken update predicts 0; a stale ST would still predict 1.
        drive(1, 0, 0, 0, 32'h10, 32'h88, 0);
        step(); idle();
        chk("arst_bht_wnt", 32'(id_pred_taken), 32'd0);
        chk("arst_branch_cnt_after", branch_cnt, 32'd1);
        chk("arst_flush_after", 32'(flush), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
